// File: rtl/generador_minas.sv
// Board generator for the 8x8 buscaminas game.
// On an `iniciar` pulse: clear the board, place `cantBombas` mines at cells picked by a
// free-running 16-bit Fibonacci LFSR, then compute every cell's 3x3 neighbour mine count.
// Optional feature macro: GENMINAS_EXCLUIR_EN (keeps the latched cell and its in-board
// neighbourhood free of mines; clamps the mine count to 55).
`timescale 1ns/1ps

module generador_minas #(
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         iniciar,
  input  logic [5:0]   cantBombas,
  input  logic [2:0]   i_excluida,
  input  logic [2:0]   j_excluida,
  output logic [63:0]  minas,
  output logic [255:0] cuentas,
  output logic         ocupado,
  output logic         listo,
  output logic [2:0]   estado
);

  // An all-zero LFSR would lock up, so a zero seed is replaced.
  localparam logic [15:0] Semilla = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StLimpiar = 3'd1,
    StColocar = 3'd2,
    StContar  = 3'd3,
    StListo   = 3'd4
  } estado_e;

  estado_e        state_q, state_d;
  logic [15:0]    lfsr_q, lfsr_d;
  logic [5:0]     objetivo_q, objetivo_d;
  logic [5:0]     colocadas_q, colocadas_d;
  logic [5:0]     k_q, k_d;
  logic [63:0]    minas_q, minas_d;
  logic [255:0]   cuentas_q, cuentas_d;

  logic [5:0]     cand;
  logic [5:0]     objetivo_nuevo;
  logic           excluida;
  logic [3:0]     vecinos;

  assign cand = lfsr_q[5:0];

  function automatic logic en_tablero(input int r, input int c);
    return (r >= 0) && (r < 8) && (c >= 0) && (c < 8);
  endfunction

  function automatic logic [5:0] celda(input int r, input int c);
    return 6'(r * 8 + c);
  endfunction

`ifdef GENMINAS_EXCLUIR_EN
  logic [2:0] exc_i_q, exc_j_q;

  function automatic logic cerca(input logic [2:0] a, input logic [2:0] b);
    return (a >= b) ? ((a - b) <= 3'd1) : ((b - a) <= 3'd1);
  endfunction

  assign objetivo_nuevo = (cantBombas > 6'd55) ? 6'd55 : cantBombas;
  assign excluida       = cerca(cand[5:3], exc_i_q) && cerca(cand[2:0], exc_j_q);

  // Protected cell is captured together with the mine count at start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exc_i_q <= 3'd0;
      exc_j_q <= 3'd0;
    end else if (state_q == StIdle && iniciar) begin
      exc_i_q <= i_excluida;
      exc_j_q <= j_excluida;
    end
  end
`else
  logic unused_excl;
  assign unused_excl    = ^{i_excluida, j_excluida};
  assign objetivo_nuevo = cantBombas;
  assign excluida       = 1'b0;
`endif

  // Mines among the in-board neighbours of cell k (the cell itself is skipped).
  always_comb begin
    vecinos = 4'd0;
    for (int di = -1; di <= 1; di++) begin
      for (int dj = -1; dj <= 1; dj++) begin
        if ((di != 0 || dj != 0) &&
            en_tablero(int'(k_q[5:3]) + di, int'(k_q[2:0]) + dj)) begin
          vecinos = vecinos +
                    {3'b000, minas_q[celda(int'(k_q[5:3]) + di, int'(k_q[2:0]) + dj)]};
        end
      end
    end
  end

  // Next-state logic for the FSM, datapath registers and the LFSR.
  always_comb begin
    state_d     = state_q;
    lfsr_d      = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    objetivo_d  = objetivo_q;
    colocadas_d = colocadas_q;
    k_d         = k_q;
    minas_d     = minas_q;
    cuentas_d   = cuentas_q;
    unique case (state_q)
      StIdle: begin
        if (iniciar) begin
          objetivo_d = objetivo_nuevo;
          state_d    = StLimpiar;
        end
      end
      StLimpiar: begin
        minas_d     = 64'd0;
        cuentas_d   = 256'd0;
        colocadas_d = 6'd0;
        k_d         = 6'd0;
        state_d     = (objetivo_q == 6'd0) ? StContar : StColocar;
      end
      StColocar: begin
        if (!minas_q[cand] && !excluida) begin
          minas_d[cand] = 1'b1;
          colocadas_d   = colocadas_q + 6'd1;
          if (colocadas_q + 6'd1 == objetivo_q) begin
            state_d = StContar;
          end
        end
      end
      StContar: begin
        cuentas_d[{k_q, 2'b00} +: 4] = vecinos;
        k_d = k_q + 6'd1;
        if (k_q == 6'd63) begin
          state_d = StListo;
        end
      end
      StListo: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers; reset aborts any generation in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      lfsr_q      <= Semilla;
      objetivo_q  <= 6'd0;
      colocadas_q <= 6'd0;
      k_q         <= 6'd0;
      minas_q     <= 64'd0;
      cuentas_q   <= 256'd0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      objetivo_q  <= objetivo_d;
      colocadas_q <= colocadas_d;
      k_q         <= k_d;
      minas_q     <= minas_d;
      cuentas_q   <= cuentas_d;
    end
  end

  assign minas   = minas_q;
  assign cuentas = cuentas_q;
  assign ocupado = (state_q != StIdle);
  assign listo   = (state_q == StListo);
  assign estado  = state_q;

endmodule

// File: tb/tb_generador_minas.sv
// Directed bench for generador_minas: expected boards come from a bench-side LFSR
// replica and a placement / neighbour-count model. Honours GENMINAS_EXCLUIR_EN.
`timescale 1ns/1ps

module tb_generador_minas;

  localparam logic [15:0] Seed = 16'hACE1;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         iniciar = 1'b0;
  logic [5:0]   cantBombas = 6'd0;
  logic [2:0]   i_excl = 3'd0;
  logic [2:0]   j_excl = 3'd0;
  logic [63:0]  minas;
  logic [255:0] cuentas;
  logic         ocupado;
  logic         listo;
  logic [2:0]   estado;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int listo_cnt = 0;
  logic [15:0]  m_lfsr;
  logic [63:0]  m_keep;

  always #5 clk = ~clk;

  generador_minas #(.LFSR_SEED(Seed)) dut (
    .clk        (clk),
    .rst        (rst),
    .iniciar    (iniciar),
    .cantBombas (cantBombas),
    .i_excluida (i_excl),
    .j_excluida (j_excl),
    .minas      (minas),
    .cuentas    (cuentas),
    .ocupado    (ocupado),
    .listo      (listo),
    .estado     (estado)
  );

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  // Bench replica of the free-running LFSR, kept in step with the clock.
  always @(posedge clk or negedge rst) begin
    if (!rst) m_lfsr <= Seed;
    else      m_lfsr <= lfsr_step(m_lfsr);
  end

  always @(posedge clk) begin
    if (listo) listo_cnt <= listo_cnt + 1;
  end

  function automatic logic [5:0] clamp(input logic [5:0] nb);
`ifdef GENMINAS_EXCLUIR_EN
    return (nb > 6'd55) ? 6'd55 : nb;
`else
    return nb;
`endif
  endfunction

  function automatic logic is_excl(input logic [5:0] c, input logic [2:0] ei,
                                   input logic [2:0] ej);
`ifdef GENMINAS_EXCLUIR_EN
    int dr, dc;
    dr = int'(c[5:3]) - int'(ei);
    dc = int'(c[2:0]) - int'(ej);
    return (dr >= -1) && (dr <= 1) && (dc >= -1) && (dc <= 1);
`else
    return (c != c);
`endif
  endfunction

  // l0 is the LFSR value in the first placement cycle; p returns the placement cycles.
  function automatic logic [63:0] model_place(input logic [15:0] l0, input logic [5:0] n,
                                              input logic [2:0] ei, input logic [2:0] ej,
                                              output int p);
    logic [63:0] m;
    logic [15:0] l;
    int cnt;
    m = 64'd0; l = l0; cnt = 0; p = 0;
    while (cnt < int'(n) && p < 70000) begin
      p++;
      if (!m[l[5:0]] && !is_excl(l[5:0], ei, ej)) begin
        m[l[5:0]] = 1'b1;
        cnt++;
      end
      l = lfsr_step(l);
    end
    return m;
  endfunction

  function automatic logic [255:0] model_counts(input logic [63:0] m);
    logic [255:0] r;
    int s;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        s = 0;
        for (int a = i - 1; a <= i + 1; a++)
          for (int b = j - 1; b <= j + 1; b++)
            if (a >= 0 && a < 8 && b >= 0 && b < 8 && !(a == i && b == j) && m[a*8+b])
              s++;
        r[4*(i*8+j) +: 4] = 4'(s);
      end
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full generation; repulse > 0 re-asserts iniciar that many edges after start.
  task automatic run_gen(input logic [5:0] nb, input logic [2:0] ei, input logic [2:0] ej,
                         input int repulse, input string tag, output logic [63:0] m_exp);
    logic [15:0]  l0;
    logic [255:0] c_exp;
    logic [5:0]   obj;
    int p, n, lc0;
    @(negedge clk);
    cantBombas = nb; i_excl = ei; j_excl = ej; iniciar = 1'b1;
    @(posedge clk); #1;
    iniciar = 1'b0;
    lc0 = listo_cnt;
    l0 = lfsr_step(m_lfsr);
    chk({tag, " ocupado_rise"}, ocupado, 1'b1);
    chk({tag, " estado_limpiar"}, estado, 3'd1);
    obj   = clamp(nb);
    m_exp = model_place(l0, obj, ei, ej, p);
    c_exp = model_counts(m_exp);
    n = 0;
    while (!listo && n < 70000) begin
      @(posedge clk); #1;
      n++;
      if (n == repulse) begin
        iniciar = 1'b1; cantBombas = 6'd20;
      end else begin
        iniciar = 1'b0;
      end
    end
    iniciar = 1'b0;
    // LIMPIAR(1) + COLOCAR(p) + CONTAR(64) edges before LISTO is entered.
    chk({tag, " latencia"}, n, p + 65);
    chk({tag, " minas"}, minas, m_exp);
    chk({tag, " popcount"}, $countones(minas), obj);
    chk({tag, " cuentas"}, cuentas, c_exp);
    chk({tag, " ocupado_listo"}, ocupado, 1'b1);
    @(posedge clk); #1;
    chk({tag, " listo_pulso"}, listo, 1'b0);
    chk({tag, " ocupado_cae"}, ocupado, 1'b0);
    chk({tag, " estado_idle"}, estado, 3'd0);
    chk({tag, " un_listo"}, listo_cnt - lc0, 1);
  endtask

  initial begin
    logic [63:0] m1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset estado", estado, 3'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (20) begin @(posedge clk); #1; end
    chk("idle minas", minas, 64'd0);
    chk("idle cuentas", cuentas, 256'd0);
    chk("idle ocupado", ocupado, 1'b0);
    chk("idle listo", listo, 1'b0);
    chk("idle estado", estado, 3'd0);

    run_gen(6'd10, 3'd2, 3'd5, -1, "b10", m1);
    repeat (5) begin @(posedge clk); #1; end
    chk("hold minas", minas, m1);

    run_gen(6'd0, 3'd0, 3'd0, -1, "b0", m1);
    chk("b0 vacio", minas, 64'd0);

`ifdef GENMINAS_EXCLUIR_EN
    run_gen(6'd63, 3'd0, 3'd0, -1, "excl", m1);
    chk("excl esquina", minas & 64'h0000_0000_0000_0303, 64'd0);
    chk("excl 55", $countones(minas), 55);
`else
    run_gen(6'd63, 3'd3, 3'd4, -1, "b63", m1);
    chk("b63 cuenta", $countones(minas), 63);
`endif

    run_gen(6'd5, 3'd7, 3'd7, 3, "repulso", m1);
    repeat (3) begin @(posedge clk); #1; end
    chk("repulso sin reinicio", estado, 3'd0);

    // Asynchronous abort in the middle of placement.
    @(negedge clk);
    cantBombas = 6'd40; i_excl = 3'd4; j_excl = 3'd4; iniciar = 1'b1;
    @(posedge clk); #1;
    iniciar = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    chk("abort en_colocar", estado, 3'd2);
    #3 rst = 1'b0;
    #1;
    chk("abort minas", minas, 64'd0);
    chk("abort cuentas", cuentas, 256'd0);
    chk("abort ocupado", ocupado, 1'b0);
    chk("abort listo", listo, 1'b0);
    chk("abort estado", estado, 3'd0);
    @(negedge clk);
    rst = 1'b1;
    run_gen(6'd7, 3'd1, 3'd6, -1, "post", m1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
